// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
// States, default operand width and iteration counter width.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the {rem, quo} pair left,
// trial-subtract the divisor and restore if the result is negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtract on WIDTH+1 bits so the borrow is the sign bit
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_i};
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/iterative_divider.sv
// Signed iterative divider, one quotient bit per cycle.
// Optional DIV_BY_ZERO_CHECK_EN adds a short-cut divide-by-zero path.
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
`ifdef DIV_BY_ZERO_CHECK_EN
    logic             dz_q, dz_d;
    logic             dbz_q, dbz_d;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Next-state and datapath control for the IDLE/PREP/CALC/FIX sequence
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        remo_d  = remo_q;
`ifdef DIV_BY_ZERO_CHECK_EN
        dz_d    = dz_q;
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = dividend;
                    opb_d   = divisor;
                    q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg_d = dividend[WIDTH-1];
                    state_d = PREP;
`ifdef DIV_BY_ZERO_CHECK_EN
                    dz_d    = (divisor == '0);
                    if (divisor == '0) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            PREP: begin
                // Negating -2^(W-1) yields the right unsigned magnitude
                quo_d   = opa_q[WIDTH-1] ? (~opa_q + 1'b1) : opa_q;
                dvs_d   = opb_q[WIDTH-1] ? (~opb_q + 1'b1) : opb_q;
                rem_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = CALC;
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                quot_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
                remo_d  = r_neg_q ? (~rem_q + 1'b1) : rem_q;
`ifdef DIV_BY_ZERO_CHECK_EN
                dbz_d   = dz_q;
                if (dz_q) begin
                    quot_d = '1;
                    remo_d = opa_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

`ifdef DIV_BY_ZERO_CHECK_EN
    // Divide-by-zero tracking and sticky-until-next-done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_q  <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            dz_q  <= dz_d;
            dbz_q <= dbz_d;
        end
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remo_q;

endmodule
